// File: rtl/wbq_pkg.sv
// Shared types and defaults for the write-back merge queue.
// Pure declarations: no logic, no latency.
// Entry widths follow WBQ_AW/WBQ_DW; the top's AW/DW defaults track them.
package wbq_pkg;
    localparam int WBQ_DEPTH = 4;
    localparam int WBQ_AW    = 5;
    localparam int WBQ_DW    = 32;

    localparam logic [WBQ_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [WBQ_AW-1:0] rd;
        logic [WBQ_DW-1:0] data;
    } entry_t;
endpackage

// File: rtl/wb_merge_queue_if.sv
// Bundle of write-back lanes, register-file write port, status and lookup ports.
// No logic and no latency. Stall is the only backpressure and is owned by the queue.
// The master is the pipeline or bench side. The slave is the queue.
interface wb_merge_queue_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          wb0_we;
    logic [AW-1:0] wb0_rd;
    logic [DW-1:0] wb0_data;
    logic          wb1_we;
    logic [AW-1:0] wb1_rd;
    logic [DW-1:0] wb1_data;

    logic          rf_we;
    logic [AW-1:0] rf_wr;
    logic [DW-1:0] rf_wdata;

    logic            stall;
    logic            ovf;
    logic [4*AW-1:0] lk_addr;
    logic [3:0]      lk_hit;
    logic [4*DW-1:0] lk_data;

    modport master (
        output wb0_we, wb0_rd, wb0_data, wb1_we, wb1_rd, wb1_data, lk_addr,
        input  rf_we, rf_wr, rf_wdata, stall, ovf, lk_hit, lk_data
    );

    modport slave (
        input  wb0_we, wb0_rd, wb0_data, wb1_we, wb1_rd, wb1_data, lk_addr,
        output rf_we, rf_wr, rf_wdata, stall, ovf, lk_hit, lk_data
    );
endinterface

// File: rtl/wbq_lookup.sv
// Single lookup address compared against all valid entries. Newest match wins.
// Combinational, zero latency. No backpressure.
// Entries arrive age-ordered: index 0 is oldest, and a higher index is newer.
module wbq_lookup
    import wbq_pkg::*;
#(
    parameter int DEPTH = WBQ_DEPTH
) (
    input  logic [WBQ_AW-1:0] addr,
    input  logic [DEPTH-1:0]  vld,
    input  entry_t            ents [DEPTH],
    output logic              hit,
    output logic [WBQ_DW-1:0] data
);
    always_comb begin
        hit  = 1'b0;
        data = '0;
        // Walking oldest to newest lets the last match overwrite, which gives newest priority.
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && addr != REG_ZERO && ents[i].rd == addr) begin
                hit  = 1'b1;
                data = ents[i].data;
            end
        end
    end
endmodule

// File: rtl/wb_merge_queue.sv
// Merges up to two write-back writes per cycle into one in-order register-file write port.
// Latency: an accepted write appears on rf_* in the cycle after its edge. The head pops on every non-empty edge.
// Backpressure: stall while full. Pushes under stall are dropped and set sticky ovf. WBQ_FWD_EN enables lookups.
module wb_merge_queue
    import wbq_pkg::*;
#(
    parameter int DEPTH = WBQ_DEPTH,
    parameter int AW    = WBQ_AW,
    parameter int DW    = WBQ_DW
) (
    input logic              clk,
    input logic              rst,
    wb_merge_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    typedef logic [PW-1:0] ptr_t;
    typedef logic [PW:0]   cnt_t;

    entry_t q [DEPTH];
    ptr_t   head, tail, tail1;
    cnt_t   count, npush, count_nxt;
    logic   p0, p1, pop, full, do0, do1, ovf_q;

    always_comb begin
        p1 = bus.wb1_we && (bus.wb1_rd != REG_ZERO);
        // When both lanes target the same register, the younger lane 1 value is the only one that matters.
        p0 = bus.wb0_we && (bus.wb0_rd != REG_ZERO) && !(p1 && bus.wb1_rd == bus.wb0_rd);
        pop       = (count != '0);
        full      = (count == cnt_t'(DEPTH));
        do0       = p0 && !full;
        do1       = p1 && !full;
        npush     = cnt_t'(do0) + cnt_t'(do1);
        tail1     = tail + ptr_t'(do0);
        count_nxt = count - cnt_t'(pop) + npush;
    end

    always_ff @(posedge clk) begin
        if (do0) q[tail]  <= '{rd: bus.wb0_rd, data: bus.wb0_data};
        if (do1) q[tail1] <= '{rd: bus.wb1_rd, data: bus.wb1_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            ovf_q <= 1'b0;
        end else begin
            head  <= head + ptr_t'(pop);
            tail  <= tail + ptr_t'(npush);
            count <= count_nxt;
            if (full && (p0 || p1)) ovf_q <= 1'b1;
        end
    end

    assign bus.rf_we    = pop;
    assign bus.rf_wr    = pop ? q[head].rd   : '0;
    assign bus.rf_wdata = pop ? q[head].data : '0;
    assign bus.stall    = full;
    assign bus.ovf      = ovf_q;

`ifdef WBQ_FWD_EN
    entry_t           ord [DEPTH];
    logic [DEPTH-1:0] ord_vld;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ord[i]     = q[head + ptr_t'(i)];
            ord_vld[i] = (cnt_t'(i) < count);
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_lk
        wbq_lookup #(.DEPTH(DEPTH)) u_lk (
            .addr (bus.lk_addr[g*AW +: AW]),
            .vld  (ord_vld),
            .ents (ord),
            .hit  (bus.lk_hit[g]),
            .data (bus.lk_data[g*DW +: DW])
        );
    end
`else
    logic unused_lk;
    assign unused_lk    = ^bus.lk_addr;
    assign bus.lk_hit   = '0;
    assign bus.lk_data  = '0;
`endif
endmodule

// File: tb/tb_wb_merge_queue.sv
// Directed, table-driven bench for wb_merge_queue, plus a hand-written mid-operation reset sequence.
// Lookup expectations collapse to zero when WBQ_FWD_EN is not defined.
module tb_wb_merge_queue;
`ifdef WBQ_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    wb_merge_queue_if #(.AW(5), .DW(32)) bus ();
    wb_merge_queue dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic        we0;
        logic [4:0]  rd0;
        logic [31:0] d0;
        logic        we1;
        logic [4:0]  rd1;
        logic [31:0] d1;
        logic [19:0] lka;
        logic        e_we;
        logic [4:0]  e_wr;
        logic [31:0] e_wd;
        logic        e_stall;
        logic        e_ovf;
        logic [3:0]  e_hit;
        logic [127:0] e_lkd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic we0, logic [4:0] rd0, logic [31:0] d0,
                                logic we1, logic [4:0] rd1, logic [31:0] d1, logic [19:0] lka,
                                logic e_we, logic [4:0] e_wr, logic [31:0] e_wd,
                                logic e_stall, logic e_ovf, logic [3:0] e_hit, logic [127:0] e_lkd);
        vec_t v;
        v.we0 = we0; v.rd0 = rd0; v.d0 = d0;
        v.we1 = we1; v.rd1 = rd1; v.d1 = d1; v.lka = lka;
        v.e_we = e_we; v.e_wr = e_wr; v.e_wd = e_wd;
        v.e_stall = e_stall; v.e_ovf = e_ovf; v.e_hit = e_hit; v.e_lkd = e_lkd;
        return v;
    endfunction

    function automatic logic [19:0] la(logic [4:0] a0, logic [4:0] a1, logic [4:0] a2, logic [4:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [127:0] ld(logic [31:0] d0, logic [31:0] d1, logic [31:0] d2, logic [31:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.wb0_we = v.we0; bus.wb0_rd = v.rd0; bus.wb0_data = v.d0;
        bus.wb1_we = v.we1; bus.wb1_rd = v.rd1; bus.wb1_data = v.d1;
        bus.lk_addr = v.lka;
    endtask

    initial begin
        bus.wb0_we = 0; bus.wb0_rd = 0; bus.wb0_data = 0;
        bus.wb1_we = 0; bus.wb1_rd = 0; bus.wb1_data = 0;
        bus.lk_addr = la(5, 0, 0, 0);

        // Rows: inputs driven for one edge, then the outputs expected just after that edge.
        vecs.push_back(mk(0,0,0,       0,0,0,       la(0,0,0,0), 0,0,0,         0,0,4'b0000, '0));
        vecs.push_back(mk(1,5,'h11,    0,0,0,       la(5,0,0,0), 1,5,'h11,      0,0,4'b0001, ld('h11,0,0,0)));
        vecs.push_back(mk(0,0,0,       0,0,0,       la(5,0,0,0), 0,0,0,         0,0,4'b0000, '0));
        vecs.push_back(mk(1,3,'hA,     1,4,'hB,     la(4,3,0,0), 1,3,'hA,       0,0,4'b0011, ld('hB,'hA,0,0)));
        vecs.push_back(mk(0,0,0,       0,0,0,       la(4,3,0,0), 1,4,'hB,       0,0,4'b0001, ld('hB,0,0,0)));
        vecs.push_back(mk(0,0,0,       0,0,0,       la(4,3,0,0), 0,0,0,         0,0,4'b0000, '0));
        vecs.push_back(mk(1,7,1,       1,7,2,       la(7,0,0,0), 1,7,2,         0,0,4'b0001, ld(2,0,0,0)));
        vecs.push_back(mk(1,0,'hFF,    0,0,0,       la(0,7,0,0), 0,0,0,         0,0,4'b0000, '0));
        vecs.push_back(mk(0,0,0,       0,0,0,       la(0,0,0,0), 0,0,0,         0,0,4'b0000, '0));
        vecs.push_back(mk(1,1,1,       1,2,2,       la(2,1,0,0), 1,1,1,         0,0,4'b0011, ld(2,1,0,0)));
        vecs.push_back(mk(1,3,3,       1,4,4,       la(4,1,0,0), 1,2,2,         0,0,4'b0001, ld(4,0,0,0)));
        vecs.push_back(mk(1,5,5,       1,6,6,       la(6,3,0,0), 1,3,3,         1,0,4'b0011, ld(6,3,0,0)));
        vecs.push_back(mk(1,7,'h77,    1,8,'h88,    la(7,8,6,0), 1,4,4,         0,1,4'b0100, ld(0,0,6,0)));
        vecs.push_back(mk(0,0,0,       0,0,0,       la(5,6,0,0), 1,5,5,         0,1,4'b0011, ld(5,6,0,0)));
        vecs.push_back(mk(0,0,0,       0,0,0,       la(5,6,0,0), 1,6,6,         0,1,4'b0010, ld(0,6,0,0)));
        vecs.push_back(mk(0,0,0,       0,0,0,       la(5,6,0,0), 0,0,0,         0,1,4'b0000, '0));
        vecs.push_back(mk(1,10,'h10,   1,9,1,       la(9,10,0,0),1,10,'h10,     0,1,4'b0011, ld(1,'h10,0,0)));
        vecs.push_back(mk(1,9,2,       0,0,0,       la(9,10,0,0),1,9,1,         0,1,4'b0001, ld(2,0,0,0)));
        vecs.push_back(mk(0,0,0,       0,0,0,       la(9,0,0,0), 1,9,2,         0,1,4'b0001, ld(2,0,0,0)));
        vecs.push_back(mk(0,0,0,       0,0,0,       la(9,0,0,0), 0,0,0,         0,1,4'b0000, '0));

        repeat (2) @(posedge clk);
        #1;
        check("reset rf_we", 128'(bus.rf_we), 128'(1'b0));
        check("reset stall", 128'(bus.stall), 128'(1'b0));
        check("reset ovf",   128'(bus.ovf),   128'(1'b0));
        check("reset lk_hit", 128'(bus.lk_hit), 128'(4'b0000));
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check($sformatf("row%0d rf_we", i), 128'(bus.rf_we), 128'(vecs[i].e_we));
            if (vecs[i].e_we) begin
                check($sformatf("row%0d rf_wr", i),    128'(bus.rf_wr),    128'(vecs[i].e_wr));
                check($sformatf("row%0d rf_wdata", i), 128'(bus.rf_wdata), 128'(vecs[i].e_wd));
            end
            check($sformatf("row%0d stall", i),   128'(bus.stall),  128'(vecs[i].e_stall));
            check($sformatf("row%0d ovf", i),     128'(bus.ovf),    128'(vecs[i].e_ovf));
            check($sformatf("row%0d lk_hit", i),  128'(bus.lk_hit), 128'(FWD ? vecs[i].e_hit : 4'b0000));
            check($sformatf("row%0d lk_data", i), bus.lk_data,      FWD ? vecs[i].e_lkd : 128'd0);
        end

        // Asynchronous reset mid-operation drops queued writes and clears sticky ovf.
        drive(mk(1,12,'hC, 1,13,'hD, la(13,0,0,0), 0,0,0, 0,0,4'b0000, '0));
        @(posedge clk);
        #1;
        check("pre-rst rf_wr", 128'(bus.rf_wr), 128'(5'd12));
        check("pre-rst lk_hit", 128'(bus.lk_hit), 128'(FWD ? 4'b0001 : 4'b0000));
        drive(mk(0,0,0, 0,0,0, la(13,0,0,0), 0,0,0, 0,0,4'b0000, '0));
        #2;
        rst = 1'b1;
        #1;
        check("async rst rf_we",  128'(bus.rf_we),  128'(1'b0));
        check("async rst ovf",    128'(bus.ovf),    128'(1'b0));
        check("async rst stall",  128'(bus.stall),  128'(1'b0));
        check("async rst lk_hit", 128'(bus.lk_hit), 128'(4'b0000));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post-rst rf_we", 128'(bus.rf_we), 128'(1'b0));
        check("post-rst ovf",   128'(bus.ovf),   128'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_merge_queue.md
# wb_merge_queue

Write-back merge queue for the dual-issue pipeline: accepts up to two register writes per cycle from the two write-back lanes and serialises them into the register file's single write port, in program order. It sits directly upstream of the register file, driving its write-enable/address/data inputs. It also exposes pending-write lookup ports so decode reads are never stale, and asserts a stall when it cannot absorb another dual write.

## Interface
- DEPTH, 4, queue entries; power of two, >= 2
- AW, 5, register address width
- DW, 32, data width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- wb0_we / wb0_rd / wb0_data  in  1 / AW / DW  lane 0 (older instruction) write request
- wb1_we / wb1_rd / wb1_data  in  1 / AW / DW  lane 1 (younger instruction) write request
- rf_we / rf_wr / rf_wdata  out  1 / AW / DW  write port to register file; reset 0/0/0
- stall  out  1  queue cannot accept two pushes this edge; reset 0
- ovf  out  1  sticky error: push attempted while stall high; reset 0, cleared only by rst
- lk_addr  in  4*AW  four packed lookup addresses (lane0 rs/rt, lane1 rs/rt)
- lk_hit  out  4  per-lookup hit; reset 0
- lk_data  out  4*DW  per-lookup data from newest matching entry; 0 when no hit

## Operation
- Circular FIFO of {rd, data} entries, head/tail pointers plus count (0..DEPTH).
- Push filtering per edge: request with we=1 and rd=0 discarded; if both lanes valid with same nonzero rd, lane 0 discarded (younger wins).
- Surviving pushes enqueued lane 0 first, then lane 1; zero, one or two pushes per edge.
- Drain: rf_we = (count != 0); rf_wr/rf_wdata = head entry, combinational from queue state. Head popped on every edge where count != 0.
- count_next = count - pop + pushes; push and pop on the same edge are legal, including with count == DEPTH.
- stall = (count == DEPTH), i.e. free slots after this edge's pop < 2. Upstream must present both we=0 while stall is high.
- Push while stall high: all pushes of that edge dropped, queue unchanged, ovf set.
- Lookup: lk_hit[i] = lk_addr[i] != 0 and matches any valid entry. lk_data[i] = data of the newest (closest to tail) match. In-flight wb inputs of the current cycle are not searched.

## Timing
- Write accepted at edge k: visible on rf_* during cycle k..k+1, committed in register file at edge k+1, popped at the same edge.
- Lookup covers the entry until edge k+1; after it the register file holds the value. There is no stale window.
- Dual push of distinct rd at edge k: first written at edge k+1, second at edge k+2.
- Reset mid-operation: queue emptied immediately (asynchronous), pending writes lost, all outputs return to reset values.
- Sustained dual writes from empty: count 2, 3, 4. stall asserts in the cycle after the third dual push.

## Configuration
- WBQ_FWD_EN defined: lookup logic present as described.
- Not defined: lk_hit tied 0, lk_data tied 0, no comparators synthesised. Upstream must then stall decode while count != 0. The lk_addr port remains but is ignored.

## Structure
- Package wbq_pkg: entry struct {rd, data}, default DEPTH/AW/DW constants, REG_ZERO constant.
- Sub-module wbq_lookup: one address vs all entries, newest-match priority select. Instantiated four times under WBQ_FWD_EN.

## Test plan
- Reset held then released -> rf_we=0, stall=0, ovf=0, lk_hit=0000.
- Lane 0 writes r5=0x11 at edge 1 -> cycle after: rf_we=1, rf_wr=5, rf_wdata=0x11. After edge 2: rf_we=0.
- Dual write r3=0xA, r4=0xB at edge 1 -> r3 on rf_* after edge 1, r4 after edge 2. lk_addr=4 returns hit=1, data=0xB after edge 1.
- Same rd: lane0 r7=1, lane1 r7=2 -> exactly one write, r7=2. Lane0 r0=0xFF alone -> no rf_we.
- Three consecutive dual writes (r1..r6) -> stall=1 with count 4. A fourth dual push while stall -> ovf=1 sticky, queue unchanged, r1..r6 drained in order.
- Pending r9=0x1 then r9=0x2 (queued, not drained) -> lk_addr=9 returns 0x2. Build without WBQ_FWD_EN -> lk_hit=0.
